// File: rtl/dcache_pkg.sv
// dcache_pkg
// Shared definitions for the 2-way set-associative data cache:
//   - dcache_state_e : controller FSM states
//   - offWidth / idxWidth / tagWidth : address-field widths derived from
//     the cache geometry
//   - lineWord : pick one 32-bit word out of a cache line
package dcache_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        MISS        = 3'd1,
        WRITEBACK   = 3'd2,
        REFILL      = 3'd3,
        REFILL_DONE = 3'd4
    } dcache_state_e;

    // Widest line lineWord can handle. Callers zero-extend narrower lines.
    localparam int MAX_LINE_W = 1024;

    function automatic int offWidth(input int lineW);
        return $clog2(lineW / 8);
    endfunction

    function automatic int idxWidth(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tagWidth(input int addrW, input int lineW, input int sets);
        return addrW - idxWidth(sets) - offWidth(lineW);
    endfunction

    // {word, 5'b0} is exactly the 10-bit bit offset of the word in a 1024-bit line.
    function automatic logic [31:0] lineWord(input logic [MAX_LINE_W-1:0] line,
                                             input logic [4:0] word);
        return line[{word, 5'b0} +: 32];
    endfunction

endpackage

// File: rtl/dcache_way_array.sv
// dcache_way_array
// Storage for one way of the data cache: per-set valid, dirty, tag and line.
// Reads are combinational at idx_i; a write at idx_i happens on the clock
// edge when wrEn_i is high and always marks the entry valid.
// Ports:
//   clk_i, rst_i            clock, async active-high reset (clears valid/dirty)
//   idx_i                   set index for both read and write
//   valid_o/dirty_o/tag_o/line_o  entry contents at idx_i
//   wrEn_i, wrDirty_i, wrTag_i, wrLine_i  write port
module dcache_way_array #(
    parameter int IDX_W  = 5,
    parameter int TAG_W  = 22,
    parameter int LINE_W = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [IDX_W-1:0]  idx_i,
    output logic              valid_o,
    output logic              dirty_o,
    output logic [TAG_W-1:0]  tag_o,
    output logic [LINE_W-1:0] line_o,
    input  logic              wrEn_i,
    input  logic              wrDirty_i,
    input  logic [TAG_W-1:0]  wrTag_i,
    input  logic [LINE_W-1:0] wrLine_i
);

    localparam int SETS = 1 << IDX_W;

    logic [SETS-1:0]   valid_q;
    logic [SETS-1:0]   dirty_q;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [LINE_W-1:0] line_q [SETS];

    assign valid_o = valid_q[idx_i];
    assign dirty_o = dirty_q[idx_i];
    assign tag_o   = tag_q[idx_i];
    assign line_o  = line_q[idx_i];

    // Only the status bits need reset; tag and data are qualified by valid.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (wrEn_i) begin
            valid_q[idx_i] <= 1'b1;
            dirty_q[idx_i] <= wrDirty_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wrEn_i) begin
            tag_q[idx_i]  <= wrTag_i;
            line_q[idx_i] <= wrLine_i;
        end
    end

endmodule

// File: rtl/dcache_2way_ctrl.sv
// dcache_2way_ctrl
// 2-way set-associative, write-back, write-allocate data cache controller.
// Hits are serviced combinationally; misses stall the CPU while the FSM
// writes back a dirty victim (if any) and refills the line.
// Ports:
//   clk_i, rst_i         clock, async active-high reset
//   p1_*                 CPU side: address, store data, read/write strobes,
//                        load data and stall
//   mem_*                line-wide memory side: request, write flag, line
//                        address, write-back data, refill data and ack
//   hit_cnt_o, miss_cnt_o, wb_cnt_o  saturating performance counters, present
//                        only when DCACHE_PERF_CNT_EN is defined
// LINE_W may not exceed dcache_pkg::MAX_LINE_W; WORD_W must be 32.
module dcache_2way_ctrl import dcache_pkg::*; #(
    parameter int ADDR_W = 32,
    parameter int WORD_W = 32,
    parameter int LINE_W = 256,
    parameter int SETS   = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [WORD_W-1:0] p1_data_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic              p1_MemRead_i,
    input  logic              p1_MemWrite_i,
    output logic [WORD_W-1:0] p1_data_o,
    output logic              p1_stall_o,
`ifdef DCACHE_PERF_CNT_EN
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o,
    output logic [31:0]       wb_cnt_o,
`endif
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [LINE_W-1:0] mem_data_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_enable_o,
    output logic              mem_write_o
);

    localparam int OFF_W  = offWidth(LINE_W);
    localparam int IDX_W  = idxWidth(SETS);
    localparam int TAG_W  = tagWidth(ADDR_W, LINE_W, SETS);
    localparam int WSEL_W = OFF_W - 2;
    localparam int WORDS  = LINE_W / 32;

    logic              req;
    logic [TAG_W-1:0]  p1Tag;
    logic [IDX_W-1:0]  p1Idx;
    logic [WSEL_W-1:0] wordSel;
    logic [1:0]        unusedAddrBits;

    dcache_state_e     state_q, state_d;
    logic              victimWay_q;
    logic [TAG_W-1:0]  reqTag_q;
    logic [IDX_W-1:0]  reqIdx_q;
    logic              memEnable_q, memEnable_d;
    logic              memWrite_q, memWrite_d;
    logic [ADDR_W-1:0] memAddr_q, memAddr_d;
    logic [SETS-1:0]   lru_q;

    logic [IDX_W-1:0]  arrIdx;
    logic [1:0]        wayValid, wayDirty, match, wrEn;
    logic [TAG_W-1:0]  wayTag  [2];
    logic [LINE_W-1:0] wayLine [2];
    logic              lookupPhase, hit, hitWay, victimSel, memAck, wrDirty;
    logic [TAG_W-1:0]  wrTag;
    logic [LINE_W-1:0] hitLine, mergedLine, wrLine;

    assign req            = p1_MemRead_i | p1_MemWrite_i;
    assign p1Tag          = p1_addr_i[ADDR_W-1 -: TAG_W];
    assign p1Idx          = p1_addr_i[OFF_W +: IDX_W];
    assign wordSel        = p1_addr_i[2 +: WSEL_W];
    assign unusedAddrBits = p1_addr_i[1:0];

    // While a miss is in flight the arrays are addressed by the latched
    // index, so a CPU that drops its request cannot redirect the refill.
    assign lookupPhase = (state_q == IDLE) || (state_q == REFILL_DONE);
    assign arrIdx      = lookupPhase ? p1Idx : reqIdx_q;

    for (genvar w = 0; w < 2; w++) begin : gWay
        dcache_way_array #(
            .IDX_W (IDX_W),
            .TAG_W (TAG_W),
            .LINE_W(LINE_W)
        ) uWay (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .idx_i    (arrIdx),
            .valid_o  (wayValid[w]),
            .dirty_o  (wayDirty[w]),
            .tag_o    (wayTag[w]),
            .line_o   (wayLine[w]),
            .wrEn_i   (wrEn[w]),
            .wrDirty_i(wrDirty),
            .wrTag_i  (wrTag),
            .wrLine_i (wrLine)
        );
        assign match[w] = wayValid[w] && (wayTag[w] == p1Tag);
    end

    // Hits only count in IDLE and in the REFILL_DONE replay cycle.
    assign hit        = req && lookupPhase && (|match);
    assign hitWay     = match[1];
    assign hitLine    = wayLine[hitWay];
    assign p1_stall_o = req && !hit;
    assign p1_data_o  = hit ? lineWord(MAX_LINE_W'(hitLine), 5'(wordSel)) : '0;

    always_comb begin
        mergedLine = hitLine;
        for (int w = 0; w < WORDS; w++) begin
            if (wordSel == WSEL_W'(w)) mergedLine[w*32 +: 32] = p1_data_i;
        end
    end

    // Invalid way first (way0 preferred), otherwise the LRU way.
    assign victimSel = !wayValid[0] ? 1'b0 : (!wayValid[1] ? 1'b1 : lru_q[p1Idx]);

    assign memAck = mem_ack_i && memEnable_q;

    always_comb begin
        wrEn    = 2'b00;
        wrDirty = 1'b1;
        wrTag   = p1Tag;
        wrLine  = mergedLine;
        if (state_q == REFILL && memAck) begin
            wrEn[victimWay_q] = 1'b1;
            wrDirty           = 1'b0;
            wrTag             = reqTag_q;
            wrLine            = mem_data_i;
        end else if (hit && p1_MemWrite_i) begin
            wrEn[hitWay] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        memEnable_d = memEnable_q;
        memWrite_d  = memWrite_q;
        memAddr_d   = memAddr_q;
        case (state_q)
            IDLE: begin
                if (req && !hit) state_d = MISS;
            end
            MISS: begin
                memEnable_d = 1'b1;
                if (wayValid[victimWay_q] && wayDirty[victimWay_q]) begin
                    state_d    = WRITEBACK;
                    memWrite_d = 1'b1;
                    memAddr_d  = {wayTag[victimWay_q], reqIdx_q, {OFF_W{1'b0}}};
                end else begin
                    state_d    = REFILL;
                    memWrite_d = 1'b0;
                    memAddr_d  = {reqTag_q, reqIdx_q, {OFF_W{1'b0}}};
                end
            end
            WRITEBACK: begin
                // Request stays up and flips straight to the refill.
                if (memAck) begin
                    state_d    = REFILL;
                    memWrite_d = 1'b0;
                    memAddr_d  = {reqTag_q, reqIdx_q, {OFF_W{1'b0}}};
                end
            end
            REFILL: begin
                if (memAck) begin
                    state_d     = REFILL_DONE;
                    memEnable_d = 1'b0;
                end
            end
            REFILL_DONE: state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            victimWay_q <= 1'b0;
            reqTag_q    <= '0;
            reqIdx_q    <= '0;
            memEnable_q <= 1'b0;
            memWrite_q  <= 1'b0;
            memAddr_q   <= '0;
        end else begin
            state_q     <= state_d;
            memEnable_q <= memEnable_d;
            memWrite_q  <= memWrite_d;
            memAddr_q   <= memAddr_d;
            if (state_q == IDLE && req && !hit) begin
                victimWay_q <= victimSel;
                reqTag_q    <= p1Tag;
                reqIdx_q    <= p1Idx;
            end
        end
    end

    // LRU names the way that was not touched by the latest hit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)    lru_q        <= '0;
        else if (hit) lru_q[p1Idx] <= ~hitWay;
    end

    assign mem_enable_o = memEnable_q;
    assign mem_write_o  = memWrite_q;
    assign mem_addr_o   = memAddr_q;
    assign mem_data_o   = wayLine[victimWay_q];

    // A line may live in only one way of a set.
    assert property (@(posedge clk_i) disable iff (rst_i) !(req && match[0] && match[1]));

`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] hitCnt_q, missCnt_q, wbCnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hitCnt_q  <= '0;
            missCnt_q <= '0;
            wbCnt_q   <= '0;
        end else begin
            if (state_q == IDLE && hit && hitCnt_q != '1)             hitCnt_q  <= hitCnt_q + 32'd1;
            if (state_q == IDLE && req && !hit && missCnt_q != '1)    missCnt_q <= missCnt_q + 32'd1;
            if (state_q == WRITEBACK && memAck && wbCnt_q != '1)      wbCnt_q   <= wbCnt_q + 32'd1;
        end
    end

    assign hit_cnt_o  = hitCnt_q;
    assign miss_cnt_o = missCnt_q;
    assign wb_cnt_o   = wbCnt_q;
`endif

endmodule

// File: tb/tb_dcache_2way_ctrl.sv
// tb_dcache_2way_ctrl
// Directed bench for dcache_2way_ctrl: a default-geometry instance runs the
// fill / store / second-way / write-back / reset-abort sequence, and a
// SETS=64, LINE_W=512 instance checks the wider address split.
// Counter checks are included when DCACHE_PERF_CNT_EN is defined.
module tb_dcache_2way_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b1;

    logic [31:0]  p1DataIn = '0;
    logic [31:0]  p1Addr = '0;
    logic         p1Read = 1'b0;
    logic         p1Write = 1'b0;
    logic [31:0]  p1DataOut;
    logic         p1Stall;
    logic [255:0] memDataIn = '0;
    logic         memAck = 1'b0;
    logic [255:0] memDataOut;
    logic [31:0]  memAddr;
    logic         memEnable;
    logic         memWrite;

    logic [31:0]  p2Addr = '0;
    logic         p2Read = 1'b0;
    logic [31:0]  p2DataOut;
    logic         p2Stall;
    logic [511:0] mem2DataIn = '0;
    logic         mem2Ack = 1'b0;
    logic [511:0] mem2DataOut;
    logic [31:0]  mem2Addr;
    logic         mem2Enable;
    logic         mem2Write;

`ifdef DCACHE_PERF_CNT_EN
    logic [31:0]  hitCnt, missCnt, wbCnt, hitCnt2, missCnt2, wbCnt2;
`endif

    int checkCount = 0;
    int failCount  = 0;

    localparam logic [255:0] LINE_A  = 256'h77777777_66666666_55555555_44444444_33333333_22222222_11111111_DEADBEEF;
    localparam logic [255:0] LINE_B  = 256'h87878787_86868686_85858585_84848484_83838383_82828282_81818181_B0B0B0B0;
    localparam logic [255:0] LINE_C  = 256'hC7C7C7C7_C6C6C6C6_C5C5C5C5_C4C4C4C4_C3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0;
    localparam logic [255:0] LINE_AW = 256'h77777777_66666666_55555555_44444444_33333333_22222222_12345678_DEADBEEF;

    always #5 clk = ~clk;

    dcache_2way_ctrl dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .p1_data_i    (p1DataIn),
        .p1_addr_i    (p1Addr),
        .p1_MemRead_i (p1Read),
        .p1_MemWrite_i(p1Write),
        .p1_data_o    (p1DataOut),
        .p1_stall_o   (p1Stall),
`ifdef DCACHE_PERF_CNT_EN
        .hit_cnt_o    (hitCnt),
        .miss_cnt_o   (missCnt),
        .wb_cnt_o     (wbCnt),
`endif
        .mem_data_i   (memDataIn),
        .mem_ack_i    (memAck),
        .mem_data_o   (memDataOut),
        .mem_addr_o   (memAddr),
        .mem_enable_o (memEnable),
        .mem_write_o  (memWrite)
    );

    dcache_2way_ctrl #(.SETS(64), .LINE_W(512)) dut2 (
        .clk_i        (clk),
        .rst_i        (rst),
        .p1_data_i    (32'h0),
        .p1_addr_i    (p2Addr),
        .p1_MemRead_i (p2Read),
        .p1_MemWrite_i(1'b0),
        .p1_data_o    (p2DataOut),
        .p1_stall_o   (p2Stall),
`ifdef DCACHE_PERF_CNT_EN
        .hit_cnt_o    (hitCnt2),
        .miss_cnt_o   (missCnt2),
        .wb_cnt_o     (wbCnt2),
`endif
        .mem_data_i   (mem2DataIn),
        .mem_ack_i    (mem2Ack),
        .mem_data_o   (mem2DataOut),
        .mem_addr_o   (mem2Addr),
        .mem_enable_o (mem2Enable),
        .mem_write_o  (mem2Write)
    );

    task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drive CPU inputs just after a falling edge and let combinational outputs settle.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        p1Read   = rd;
        p1Write  = wr;
        p1Addr   = addr;
        p1DataIn = data;
        #1;
    endtask

    // Wait (bounded) for a memory request, check it, then ack it after 5 cycles.
    task automatic serviceMem(input string tag, input logic expWrite, input logic [31:0] expAddr,
                              input logic [255:0] line, output logic [255:0] wbData);
        int waited = 0;
        while (memEnable !== 1'b1 && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        checkOutput({tag, "_en"}, memEnable, 1'b1);
        checkOutput({tag, "_wr"}, memWrite, expWrite);
        checkOutput({tag, "_addr"}, memAddr, expAddr);
        wbData = memDataOut;
        repeat (5) @(negedge clk);
        memAck    = 1'b1;
        memDataIn = line;
        @(negedge clk);
        memAck    = 1'b0;
        memDataIn = '0;
        #1;
    endtask

    initial begin
        logic [255:0] wbLine;
        int           waited;

        $display("[TB] start");
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rstEnable", memEnable, 1'b0);
        checkOutput("rstWrite", memWrite, 1'b0);
        checkOutput("rstAddr", memAddr, 32'h0);
        checkOutput("rstStallIdle", p1Stall, 1'b0);

        // Request during reset: everything misses.
        p1Read = 1'b1;
        p1Addr = 32'h0000_0400;
        #1;
        checkOutput("rstStallReq", p1Stall, 1'b1);
        checkOutput("rstDataReq", p1DataOut, 32'h0);

        // Cold load of 0x400 into way0.
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("coldStall", p1Stall, 1'b1);
        serviceMem("coldRefill", 1'b0, 32'h0000_0400, LINE_A, wbLine);
        checkOutput("coldDoneStall", p1Stall, 1'b0);
        checkOutput("coldDoneData", p1DataOut, 32'hDEADBEEF);
        checkOutput("coldDoneEnable", memEnable, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("coldLru", dut.lru_q[0], 1'b1);

        // Store hit, then read it back.
        applyStimulus(1'b0, 1'b1, 32'h0000_0404, 32'h12345678);
        checkOutput("storeStall", p1Stall, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0000_0404, 32'h0);
        checkOutput("storeReadback", p1DataOut, 32'h12345678);
        checkOutput("storeDirty", dut.gWay[0].uWay.dirty_q[0], 1'b1);

        // Same set, new tag: fills the invalid way1 without write-back.
        applyStimulus(1'b1, 1'b0, 32'h0000_0800, 32'h0);
        checkOutput("way1Stall", p1Stall, 1'b1);
        serviceMem("way1Refill", 1'b0, 32'h0000_0800, LINE_B, wbLine);
        checkOutput("way1Data", p1DataOut, 32'hB0B0B0B0);
        applyStimulus(1'b1, 1'b0, 32'h0000_0400, 32'h0);
        checkOutput("way0StillHit", p1Stall, 1'b0);
        checkOutput("way0StillData", p1DataOut, 32'hDEADBEEF);
        applyStimulus(1'b1, 1'b0, 32'h0000_0800, 32'h0);
        checkOutput("way1Hit", p1DataOut, 32'hB0B0B0B0);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("lruWay0", dut.lru_q[0], 1'b0);

        // Both ways valid, way0 dirty and LRU: write-back then refill.
        applyStimulus(1'b1, 1'b0, 32'h0000_0C00, 32'h0);
        checkOutput("evictStall", p1Stall, 1'b1);
        serviceMem("evictWb", 1'b1, 32'h0000_0400, LINE_C, wbLine);
        checkOutput("evictWbData", wbLine, LINE_AW);
        checkOutput("evictNoGapEn", memEnable, 1'b1);
        serviceMem("evictRefill", 1'b0, 32'h0000_0C00, LINE_C, wbLine);
        checkOutput("evictData", p1DataOut, 32'hC0C0C0C0);
        checkOutput("evictClean", dut.gWay[0].uWay.dirty_q[0], 1'b0);
`ifdef DCACHE_PERF_CNT_EN
        checkOutput("wbCnt", wbCnt, 32'd1);
        checkOutput("missCnt", missCnt, 32'd3);
`endif
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);

        // Reset in the middle of a refill abandons the transfer.
        applyStimulus(1'b1, 1'b0, 32'h0000_2000, 32'h0);
        waited = 0;
        while (memEnable !== 1'b1 && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        checkOutput("abortReqEn", memEnable, 1'b1);
        rst = 1'b1;
        #1;
        checkOutput("abortAsyncEn", memEnable, 1'b0);
        checkOutput("abortStallFollowsReq", p1Stall, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        memAck    = 1'b1;
        memDataIn = LINE_A;
        @(negedge clk);
        memAck    = 1'b0;
        memDataIn = '0;
        #1;
        checkOutput("lateAckEn", memEnable, 1'b0);
        checkOutput("lateAckAddr", memAddr, 32'h0);
        checkOutput("lateAckValid", dut.gWay[1].uWay.valid_q[0], 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0000_0800, 32'h0);
        checkOutput("postRstMiss", p1Stall, 1'b1);
        serviceMem("postRstRefill", 1'b0, 32'h0000_0800, LINE_B, wbLine);
        checkOutput("postRstData", p1DataOut, 32'hB0B0B0B0);
`ifdef DCACHE_PERF_CNT_EN
        checkOutput("postRstMissCnt", missCnt, 32'd1);
        checkOutput("postRstWbCnt", wbCnt, 32'd0);
`endif
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);

        // Wider geometry: 0x1FC0 is set 63, word 0, tag 1.
        p2Read = 1'b1;
        p2Addr = 32'h0000_1FC0;
        #1;
        checkOutput("wideStall", p2Stall, 1'b1);
        waited = 0;
        while (mem2Enable !== 1'b1 && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        checkOutput("wideEn", mem2Enable, 1'b1);
        checkOutput("wideWr", mem2Write, 1'b0);
        checkOutput("wideAddr", mem2Addr, 32'h0000_1FC0);
        repeat (5) @(negedge clk);
        mem2Ack    = 1'b1;
        mem2DataIn = {480'h0, 32'hA5A5F00D};
        @(negedge clk);
        mem2Ack    = 1'b0;
        mem2DataIn = '0;
        #1;
        checkOutput("wideDoneStall", p2Stall, 1'b0);
        checkOutput("wideDoneData", p2DataOut, 32'hA5A5F00D);
        @(negedge clk);
        #1;
        checkOutput("wideHitData", p2DataOut, 32'hA5A5F00D);
        checkOutput("wideLru", dut2.lru_q[63], 1'b1);
        p2Read = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
